// File: rtl/ifetch.sv
// Instruction fetch front end: PC register, in-order fetch queue, valid/ready to decode.
// Optional performance counters are compiled in when IFETCH_PERF_EN is defined.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                icache_addr,
  input  logic [31:0]                icache_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(FQ_DEPTH):0]  fq_count,
  output logic [31:0]                perf_fetch_cnt,
  output logic [31:0]                perf_full_cnt
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_inst_q [FQ_DEPTH];
  logic          full, pop, push;

  always_comb begin
    full  = (cnt_q == DEPTH_C);
    pop   = inst_valid & inst_ready;
    push  = !redirect_valid & (!full | pop);
    pc_d  = pc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redirect_valid) begin
      // A same-cycle pop is still a completed handshake; the queue is dropped regardless.
      pc_d  = {redirect_pc[31:2], 2'b00};
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Queue storage carries no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_q[wr_q]   <= pc_q;
      fq_inst_q[wr_q] <= icache_data;
    end
  end

  always_comb begin
    icache_addr = pc_q;
    inst_valid  = (cnt_q != '0);
    fq_count    = cnt_q;
    inst        = inst_valid ? fq_inst_q[rd_q] : '0;
    inst_pc     = inst_valid ? fq_pc_q[rd_q]   : '0;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_full_q, perf_full_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_full_d  = perf_full_q;
    if (push) perf_fetch_d = perf_fetch_q + 32'd1;
    if (full && !pop && !redirect_valid) perf_full_d = perf_full_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_full_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_full_q  <= perf_full_d;
    end
  end

  always_comb begin
    perf_fetch_cnt = perf_fetch_q;
    perf_full_cnt  = perf_full_q;
  end
`else
  always_comb begin
    perf_fetch_cnt = '0;
    perf_full_cnt  = '0;
  end
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch front end: the requesting side of the instruction memory's combinational read port. Holds the PC, drives the fetch address, captures returned instruction words with their PCs into a small in-order fetch queue, and presents them to decode over a valid/ready handshake. Redirects from execute (branches and jumps) flush the queue and restart fetch at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `FQ_DEPTH`, 4: number of fetch-queue entries; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_addr`  out  32  byte address to instruction memory; equals the PC register.
- `icache_data`  in  32  instruction word returned combinationally for `icache_addr`, same cycle.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and forced to 0.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts the head.
- `inst`  out  32  instruction at the queue head.
- `inst_pc`  out  32  PC of the head instruction.
- `fq_count`  out  $clog2(FQ_DEPTH)+1  current occupancy.
- `perf_fetch_cnt`  out  32  instructions enqueued (see Configuration).
- `perf_full_cnt`  out  32  cycles with fetch blocked by a full queue (see Configuration).

## Operation
- State: PC register, circular queue of `FQ_DEPTH` {pc, inst} entries, read and write pointers, occupancy count.
- `pop` = `inst_valid & inst_ready`. `inst_valid` = (count != 0). `inst`/`inst_pc` come from the head entry with no bypass from `icache_data`.
- `push` = `!redirect_valid & (count < FQ_DEPTH | pop)`. On push, write {PC, `icache_data`} at the write pointer and set PC <= PC + 4.
- Full queue with simultaneous pop: push and pop both occur; count unchanged.
- Full queue without pop: no push; PC holds; `icache_addr` stays stable.
- Redirect: pointers and count reset to 0; PC <= {`redirect_pc`[31:2], 2'b00}; no push that cycle. A pop in the same cycle counts as a completed handshake for the old head, which is then discarded along with the rest of the queue.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Pointers wrap modulo `FQ_DEPTH`.

## Timing
- Reset (asynchronous, immediate): PC = `RESET_PC`, `icache_addr` = `RESET_PC`, count = 0, `inst_valid` = 0, `fq_count` = 0, `inst`/`inst_pc` = 0, and perf counters = 0. Queue storage is not required to reset, but outputs read 0 while empty.
- Reset asserted mid-operation discards all queued entries and does not complete any handshake.
- After the first edge following `rst_n` release, the entry for `RESET_PC` is enqueued, and `inst_valid` is 1 from that cycle.
- Fetch-to-decode latency: 1 cycle. Sustained throughput: 1 instruction per cycle while `inst_ready` = 1.
- Redirect taken at edge N: `icache_addr` = new PC after N, first new instruction enqueued at N+1, and `inst_valid` = 1 after N+1. The redirect bubble is 1 empty cycle.
- Back-to-back redirects: the last one wins, and each redirect flushes the queue.

## Configuration
- `IFETCH_PERF_EN` defined: `perf_fetch_cnt` increments on every push and `perf_full_cnt` increments on every cycle with count == `FQ_DEPTH` and no pop and no redirect. Both counters are 32-bit, wrap, and are cleared only by reset.
- Not defined: counter logic is not compiled; both ports remain and are tied to 0.

## Test plan
- Reset with `RESET_PC`=0 and `inst_ready`=1, memory word at address k·4 = k: `inst`/`inst_pc` sequence (0,0),(1,4),(2,8)… one per cycle, and `inst_valid` stays high continuously.
- `inst_ready`=0 for 10 cycles with `FQ_DEPTH`=4: `fq_count` reaches 4 after 4 edges, `icache_addr` freezes at 0x10, and `perf_full_cnt`=6 (when `IFETCH_PERF_EN` is defined, otherwise 0). Releasing ready then delivers PCs 0,4,8,0xC,0x10 in order with no gap.
- Redirect to 0x103 while the queue holds 3 entries: `fq_count`=0 and `inst_valid`=0 next cycle, `icache_addr`=0x100, and the following cycle `inst_pc`=0x100.
- Redirect in the same cycle as a pop from a full queue: the popped entry is consumed once, no stale entry ever appears, and the first valid output after the redirect is the redirect target.
- PC wrap: redirect to 0xFFFF_FFF8 with ready=1 gives `inst_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- `rst_n` pulsed low asynchronously mid-stream (between edges): outputs immediately show `inst_valid`=0 and `icache_addr`=`RESET_PC`, and fetch restarts from `RESET_PC` after release.
